parity_block_ctrl: RTL and testbench

//  Sequences the 8-bit XOR-reduction parity datapath over a block of bytes.
//  Per byte: checks the parity bit and counts mismatches.
//  Per block: accumulates an XOR (LRC) of all data bytes, then checks it

---
 rtl/parity_block_ctrl.sv | 123 ++++++++++++
 tb/tb_parity_block_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_block_ctrl.sv
// Block controller for a byte stream: per-byte parity checking with a saturating
// error count, plus an XOR longitudinal check (LRC) against a trailing byte.
module parity_block_ctrl #(
  parameter int LEN_W = 8,
  parameter int ERR_W = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_par,
  output logic             busy,
  output logic             done,
  output logic             lrc_ok,
  output logic [7:0]       lrc_out,
  output logic [ERR_W-1:0] par_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_LRC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [7:0]       r_lrc;
  logic             r_ok;
  logic [ERR_W-1:0] r_err;
  logic             w_accept;
  logic             w_par_bad;

  // Error counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) return v;
    return v + ERR_W'(1);
  endfunction

  assign in_ready  = (r_state == S_DATA) || (r_state == S_LRC);
  assign w_accept  = in_valid & in_ready;
  assign w_cnt_inc = r_cnt + LEN_W'(1);
  assign w_par_bad = ((^in_data) ^ ODD) != in_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (blk_len == '0) ? S_LRC : S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (w_accept && (w_cnt_inc == r_len)) w_state_nxt = S_LRC;
      end
      S_LRC: begin
        busy = 1'b1;
        if (w_accept) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
      r_lrc <= '0;
      r_ok  <= 1'b0;
      r_err <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len <= blk_len;
            r_cnt <= '0;
            r_lrc <= '0;
            r_ok  <= 1'b0;
            r_err <= '0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_lrc <= r_lrc ^ in_data;
            r_cnt <= w_cnt_inc;
            if (w_par_bad) r_err <= sat_inc(r_err);
          end
        end
        S_LRC: begin
          // The trailing byte is compared, never folded into the LRC.
          if (w_accept) begin
            r_ok <= (in_data == r_lrc);
            if (w_par_bad) r_err <= sat_inc(r_err);
          end
        end
        default: ;
      endcase
    end
  end

  assign lrc_ok      = r_ok;
  assign lrc_out     = r_lrc;
  assign par_err_cnt = r_err;

endmodule

// File: tb/tb_parity_block_ctrl.sv
// Directed bench for parity_block_ctrl: a queue-based block model checked every
// cycle against two instances (default error width and a 2-bit saturating one).
module tb_parity_block_ctrl;

  localparam bit ODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] blk_len = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_par = 1'b0;

  logic       in_ready_a, busy_a, done_a, lrc_ok_a;
  logic [7:0] lrc_out_a, err_a;
  logic       in_ready_b, busy_b, done_b, lrc_ok_b;
  logic [7:0] lrc_out_b;
  logic [1:0] err_b;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model: bytes still owed in the block (data + LRC), done pending, and the
  // received bytes of the current block from which status is derived.
  int         m_rem  = 0;
  bit         m_done = 1'b0;
  int         m_len  = 0;
  bit         m_ok   = 1'b0;
  logic [7:0] q_d[$];
  logic       q_p[$];

  always #5 clk = ~clk;

  parity_block_ctrl #(.LEN_W(8), .ERR_W(8), .ODD(ODD)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_len(blk_len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_par(in_par),
    .busy(busy_a), .done(done_a), .lrc_ok(lrc_ok_a), .lrc_out(lrc_out_a),
    .par_err_cnt(err_a)
  );

  parity_block_ctrl #(.LEN_W(8), .ERR_W(2), .ODD(ODD)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_len(blk_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_par(in_par),
    .busy(busy_b), .done(done_b), .lrc_ok(lrc_ok_b), .lrc_out(lrc_out_b),
    .par_err_cnt(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] exp_lrc();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < q_d.size() && i < m_len; i++) x ^= q_d[i];
    return x;
  endfunction

  function automatic int exp_err(input int w);
    int n = 0;
    int mx = (1 << w) - 1;
    for (int i = 0; i < q_d.size(); i++)
      if (((^q_d[i]) ^ ODD) != q_p[i]) n++;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_done = 1'b0; m_len = 0; m_ok = 1'b0;
    q_d.delete(); q_p.delete();
  endtask

  task automatic model_step();
    if (!rst_n) return;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem == 0) begin
      if (start) begin
        m_len = int'(blk_len);
        m_rem = int'(blk_len) + 1;
        m_ok  = 1'b0;
        q_d.delete(); q_p.delete();
      end
    end else if (in_valid) begin
      q_d.push_back(in_data);
      q_p.push_back(in_par);
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_ok   = (in_data == exp_lrc());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic p, input int gap);
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1; in_data = d; in_par = p;
    for (int k = 0; k < 50 && m_rem == 0; k++) step();
    if (m_rem == 0) chk("send_timeout", 32'd0, 32'd1);
    else step();
    in_valid = 1'b0; in_data = ~d; in_par = ~p;
  endtask

  task automatic run_blk(input int len, input logic [7:0] d[4], input logic p[4],
                         input logic [7:0] lb, input logic lp, input int gap);
    start = 1'b1; blk_len = 8'(len); step(); start = 1'b0;
    for (int i = 0; i < len; i++) send(d[i], p[i], gap);
    send(lb, lp, gap);
  endtask

  task automatic chk_final(input string t, input logic [7:0] lrc, input logic ok,
                           input int ea, input int eb);
    chk({t, "_done"},   32'(done_a),    32'd1);
    chk({t, "_lrc"},    32'(lrc_out_a), 32'(lrc));
    chk({t, "_ok"},     32'(lrc_ok_a),  32'(ok));
    chk({t, "_err_a"},  32'(err_a),     32'(ea));
    chk({t, "_err_b"},  32'(err_b),     32'(eb));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready_a", 32'(in_ready_a), 32'(m_rem > 0));
        chk("busy_a",     32'(busy_a),     32'((m_rem > 0) || m_done));
        chk("done_a",     32'(done_a),     32'(m_done));
        chk("lrc_ok_a",   32'(lrc_ok_a),   32'(m_ok));
        chk("lrc_out_a",  32'(lrc_out_a),  32'(exp_lrc()));
        chk("err_a",      32'(err_a),      32'(exp_err(8)));
        chk("in_ready_b", 32'(in_ready_b), 32'(m_rem > 0));
        chk("done_b",     32'(done_b),     32'(m_done));
        chk("lrc_ok_b",   32'(lrc_ok_b),   32'(m_ok));
        chk("lrc_out_b",  32'(lrc_out_b),  32'(exp_lrc()));
        chk("err_b",      32'(err_b),      32'(exp_err(2)));
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", 32'(in_ready_a), 32'd0);
    chk("rst_busy",  32'(busy_a),     32'd0);
    chk("rst_lrc",   32'(lrc_out_a),  32'd0);
    chk("rst_err",   32'(err_a),      32'd0);
    #10 rst_n = 1'b1;
    chk_en = 1'b1;
    step(); step();

    // T1 good block
    run_blk(2, '{8'hBA, 8'h0F, 8'h00, 8'h00}, '{1'b1, 1'b0, 1'b0, 1'b0}, 8'hB5, 1'b1, 0);
    chk_final("T1", 8'hB5, 1'b1, 0, 0);
    step();
    chk("T1_hold_lrc", 32'(lrc_out_a), 32'h0000_00B5);
    chk("T1_idle_done", 32'(done_a), 32'd0);

    // T2 bad parity bit; start during DONE is ignored, next IDLE cycle honoured
    run_blk(2, '{8'hBA, 8'h0F, 8'h00, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0}, 8'hB5, 1'b1, 1);
    chk_final("T2", 8'hB5, 1'b1, 1, 1);
    start = 1'b1; blk_len = 8'd7; step(); start = 1'b0;
    chk("T2_done_start_ignored", 32'(busy_a), 32'd0);

    // T3 bad LRC byte
    run_blk(2, '{8'hBA, 8'h0F, 8'h00, 8'h00}, '{1'b1, 1'b0, 1'b0, 1'b0}, 8'h00, 1'b0, 0);
    chk_final("T3", 8'hB5, 1'b0, 0, 0);
    step();

    // T4 zero-length block with source stalls
    run_blk(0, '{8'h00, 8'h00, 8'h00, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0}, 8'h00, 1'b0, 3);
    chk_final("T4", 8'h00, 1'b1, 0, 0);
    step();

    // T5 every byte carries a wrong parity bit: 5 mismatches
    run_blk(4, '{8'h01, 8'h02, 8'h04, 8'h08}, '{1'b0, 1'b0, 1'b0, 1'b0}, 8'h0F, 1'b1, 0);
    chk_final("T5", 8'h0F, 1'b1, 5, 3);
    step();

    // T6 ignored start mid-block, then reset after the first byte
    start = 1'b1; blk_len = 8'd2; step(); start = 1'b0;
    start = 1'b1; blk_len = 8'd0; step(); start = 1'b0;
    send(8'hBA, 1'b1, 0);
    chk("T6_partial_lrc", 32'(lrc_out_a), 32'h0000_00BA);
    chk("T6_still_busy",  32'(busy_a),    32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("T6_rst_ready", 32'(in_ready_a), 32'd0);
    chk("T6_rst_busy",  32'(busy_a),     32'd0);
    chk("T6_rst_done",  32'(done_a),     32'd0);
    chk("T6_rst_lrc",   32'(lrc_out_a),  32'd0);
    chk("T6_rst_ok",    32'(lrc_ok_a),   32'd0);
    step(); step();
    chk("T6_no_done", 32'(done_a), 32'd0);
    #4 rst_n = 1'b1;
    step();
    run_blk(2, '{8'hBA, 8'h0F, 8'h00, 8'h00}, '{1'b1, 1'b0, 1'b0, 1'b0}, 8'hB5, 1'b1, 0);
    chk_final("T6", 8'hB5, 1'b1, 0, 0);
    step(); step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
